// File: rtl/cpu_mem_arbiter_pkg.sv
// cpu_mem_arbiter_pkg: arbiter state encoding and default bus widths shared with the datapath
package cpu_mem_arbiter_pkg;
  localparam int DEF_DATA_W   = 16;
  localparam int DEF_ADDR_W   = 16;
  localparam int DEF_MAX_WAIT = 15;
  typedef enum logic [2:0] {
    ARB_IDLE,
    ARB_D_REQ,
    ARB_D_RESP,
    ARB_F_REQ,
    ARB_F_RESP
  } arb_state_t;
  function automatic logic is_wait(arb_state_t s);
    return s != ARB_IDLE;
  endfunction
endpackage

// File: rtl/cpu_mem_arbiter_sat_ctr.sv
// cpu_mem_arbiter_sat_ctr: width-parametrised up counter that sticks at all-ones
module cpu_mem_arbiter_sat_ctr #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);
  logic [W-1:0] r_q;
  assign q = r_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_q <= '0;
    else if (clr) r_q <= '0;
    else if (inc && !(&r_q)) r_q <= r_q + 1'b1;
endmodule

// File: rtl/cpu_mem_arbiter.sv
// cpu_mem_arbiter: merges fetch and load/store onto one memory port, stalling the pipeline until done.
// Define CPU_ARB_PERF_EN to add the perf_stall_cnt / perf_conflict_cnt counters.
module cpu_mem_arbiter
  import cpu_mem_arbiter_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_rd,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              stall,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_gnt,
  input  logic              m_rvalid,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              err_timeout
`ifdef CPU_ARB_PERF_EN
  ,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_conflict_cnt
`endif
);
  localparam int CW = $clog2(MAX_WAIT + 1);
  arb_state_t r_state, w_next;
  logic r_d_done, r_f_done, r_m_req, r_m_we, r_err;
  logic [ADDR_W-1:0] r_m_addr, w_addr_nxt;
  logic [DATA_W-1:0] r_m_wdata, w_wdata_nxt, r_if_rdata, r_d_rdata;
  logic [CW-1:0] w_wait_cnt;
  logic w_d_any, w_d_cpl, w_f_cpl, w_d_done_nxt, w_f_done_nxt, w_wait, w_err_set;
  logic w_load, w_req_nxt, w_we_nxt;
  assign w_d_any      = d_rd | d_wr;
  assign w_d_cpl      = (r_state == ARB_D_REQ && m_gnt && r_m_we) || (r_state == ARB_D_RESP && m_rvalid);
  assign w_f_cpl      = r_state == ARB_F_RESP && m_rvalid;
  assign w_d_done_nxt = r_d_done | w_d_cpl;
  assign w_f_done_nxt = r_f_done | w_f_cpl;
  assign stall        = reset & ((w_d_any & ~w_d_done_nxt) | (if_req & ~w_f_done_nxt));
  assign w_wait       = is_wait(r_state);
  // a response landing on the last allowed cycle is still in time
  assign w_err_set    = w_wait & ~(w_d_cpl | w_f_cpl) & (w_wait_cnt >= CW'(MAX_WAIT));
  assign m_req        = r_m_req;
  assign m_we         = r_m_we;
  assign m_addr       = r_m_addr;
  assign m_wdata      = r_m_wdata;
  assign if_rdata     = r_if_rdata;
  assign d_rdata      = r_d_rdata;
  assign err_timeout  = r_err;
  cpu_mem_arbiter_sat_ctr #(.W(CW)) u_wait_ctr (
    .clk(clk), .reset(reset), .clr(r_state == ARB_IDLE), .inc(w_wait), .q(w_wait_cnt)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_state    <= ARB_IDLE;
      r_d_done   <= 1'b0;
      r_f_done   <= 1'b0;
      r_m_req    <= 1'b0;
      r_m_we     <= 1'b0;
      r_m_addr   <= '0;
      r_m_wdata  <= '0;
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_d_done  <= stall ? w_d_done_nxt : 1'b0;
      r_f_done  <= stall ? w_f_done_nxt : 1'b0;
      r_m_req   <= w_req_nxt;
      r_m_we    <= w_we_nxt;
      r_m_addr  <= w_addr_nxt;
      r_m_wdata <= w_wdata_nxt;
      r_err     <= r_err | w_err_set;
      if (r_state == ARB_D_RESP && m_rvalid) r_d_rdata <= m_rdata;
      if (w_f_cpl) r_if_rdata <= m_rdata;
    end
  // loads and stores belong to the older instruction, so they win over fetch
  always_comb begin
    w_next = r_state;
    case (r_state)
      ARB_IDLE:   w_next = (w_d_any && !r_d_done) ? ARB_D_REQ : (if_req && !r_f_done) ? ARB_F_REQ : ARB_IDLE;
      ARB_D_REQ:  if (m_gnt) w_next = r_m_we ? ARB_IDLE : ARB_D_RESP;
      ARB_D_RESP: if (m_rvalid) w_next = ARB_IDLE;
      ARB_F_REQ:  if (m_gnt) w_next = ARB_F_RESP;
      ARB_F_RESP: if (m_rvalid) w_next = ARB_IDLE;
      default:    w_next = ARB_IDLE;
    endcase
  end
  always_comb begin
    w_load      = r_state == ARB_IDLE && w_next != ARB_IDLE;
    w_req_nxt   = w_next == ARB_D_REQ || w_next == ARB_F_REQ;
    w_we_nxt    = w_load ? (w_next == ARB_D_REQ && d_wr) : (w_req_nxt && r_m_we);
    w_addr_nxt  = !w_load ? r_m_addr : (w_next == ARB_D_REQ) ? d_addr : if_addr;
    w_wdata_nxt = (w_load && w_next == ARB_D_REQ) ? d_wdata : r_m_wdata;
  end
`ifdef CPU_ARB_PERF_EN
  logic w_conflict;
  assign w_conflict = (w_d_any & ~w_d_done_nxt) & (if_req & ~w_f_done_nxt);
  cpu_mem_arbiter_sat_ctr #(.W(32)) u_perf_stall (
    .clk(clk), .reset(reset), .clr(1'b0), .inc(stall), .q(perf_stall_cnt)
  );
  cpu_mem_arbiter_sat_ctr #(.W(32)) u_perf_conflict (
    .clk(clk), .reset(reset), .clr(1'b0), .inc(w_conflict), .q(perf_conflict_cnt)
  );
`endif
endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// tb_cpu_mem_arbiter: directed and random instruction steps against a transaction-level memory model
module tb_cpu_mem_arbiter;
  localparam int MW = 15;
  logic clk = 0, reset = 0, if_req = 0, d_rd = 0, d_wr = 0, m_gnt = 0, m_rvalid = 0;
  logic [15:0] if_addr = 0, d_addr = 0, d_wdata = 0, m_rdata = 0;
  logic [15:0] if_rdata, d_rdata, m_addr, m_wdata;
  logic stall, m_req, m_we, err_timeout;
`ifdef CPU_ARB_PERF_EN
  logic [31:0] perf_stall_cnt, perf_conflict_cnt;
  logic [31:0] ps, pc;
`endif
  cpu_mem_arbiter dut (
    .clk(clk), .reset(reset), .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata),
    .stall(stall), .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .err_timeout(err_timeout)
`ifdef CPU_ARB_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_conflict_cnt(perf_conflict_cnt)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {
    bit          we;
    logic [15:0] addr;
    logic [15:0] wdata;
    bit          is_d;
    int          gd;
    int          rd;
  } op_t;
  op_t ops[$];
  logic [15:0] rdq[$];
  int n_tests = 0, n_fail = 0;
  logic [15:0] exp_d = 0, exp_f = 0;
  bit exp_err = 0;
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // one pipeline step: the model lists the memory ops in priority order with their gnt/rvalid delays
  task automatic run(string tag, bit drd, bit dwr, bit ifr, logic [15:0] da, logic [15:0] dwd,
                     logic [15:0] fa, int dg, int dr, int fg, int fr);
    op_t o;
    int k = 0, gcnt = 0, rcnt = 0, stalls = 0, cyc = 0, exp_stall = 0;
    bit in_resp = 0, done = 0;
    ops.delete();
    if (drd | dwr) begin
      o.we = dwr; o.addr = da; o.wdata = dwd; o.is_d = 1; o.gd = dg; o.rd = dr;
      ops.push_back(o);
    end
    if (ifr) begin
      o.we = 0; o.addr = fa; o.wdata = 0; o.is_d = 0; o.gd = fg; o.rd = fr;
      ops.push_back(o);
    end
    foreach (ops[i]) begin
      int w;
      w = ops[i].gd + 1 + (ops[i].we ? 0 : ops[i].rd + 1);
      exp_stall += w + 1;
      if (w > MW + 1) exp_err = 1;
    end
    if (ops.size() != 0) exp_stall -= 1;
    d_rd = drd; d_wr = dwr; if_req = ifr; d_addr = da; d_wdata = dwd; if_addr = fa;
    while (!done && cyc < 200) begin
      m_gnt = 0;
      m_rvalid = 0;
      if (in_resp) begin
        if (rcnt == ops[k].rd) begin
          m_rvalid = 1;
          m_rdata = (rdq.size() != 0) ? rdq.pop_front() : 16'($urandom);
          if (ops[k].is_d) exp_d = m_rdata;
          else exp_f = m_rdata;
          in_resp = 0;
          k++;
        end else rcnt++;
      end else if (m_req && k < ops.size()) begin
        if (gcnt == ops[k].gd) begin
          m_gnt = 1;
          gcnt = 0;
          chk({tag, " addr"}, 32'(m_addr), 32'(ops[k].addr));
          chk({tag, " we"}, 32'(m_we), 32'(ops[k].we));
          if (ops[k].we) begin
            chk({tag, " wdata"}, 32'(m_wdata), 32'(ops[k].wdata));
            k++;
          end else begin
            in_resp = 1;
            rcnt = 0;
          end
        end else gcnt++;
      end
      #1;
      if (stall) stalls++;
      else done = 1;
      @(negedge clk);
      cyc++;
    end
    m_gnt = 0;
    m_rvalid = 0;
    chk({tag, " finished"}, 32'(done), 32'd1);
    chk({tag, " stall cycles"}, 32'(stalls), 32'(exp_stall));
    chk({tag, " ops served"}, 32'(k), 32'(ops.size()));
    chk({tag, " d_rdata"}, 32'(d_rdata), 32'(exp_d));
    chk({tag, " if_rdata"}, 32'(if_rdata), 32'(exp_f));
    chk({tag, " err"}, 32'(err_timeout), 32'(exp_err));
    chk({tag, " m_req idle"}, 32'(m_req), 32'd0);
  endtask
  task automatic do_reset(string tag);
    reset = 0; d_rd = 0; d_wr = 0; if_req = 0; m_gnt = 0; m_rvalid = 0;
    exp_d = 0; exp_f = 0; exp_err = 0;
    #1;
    chk({tag, " m_req"}, 32'(m_req), 32'd0);
    chk({tag, " m_we"}, 32'(m_we), 32'd0);
    chk({tag, " m_addr"}, 32'(m_addr), 32'd0);
    chk({tag, " m_wdata"}, 32'(m_wdata), 32'd0);
    chk({tag, " d_rdata"}, 32'(d_rdata), 32'd0);
    chk({tag, " if_rdata"}, 32'(if_rdata), 32'd0);
    chk({tag, " err"}, 32'(err_timeout), 32'd0);
    chk({tag, " stall"}, 32'(stall), 32'd0);
    @(negedge clk);
    reset = 1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    @(negedge clk);
    do_reset("reset");
    rdq.push_back(16'hA5C3);
    run("t1 fetch", 0, 0, 1, 16'h0, 16'h0, 16'h0010, 0, 0, 0, 0);
    chk("t1 if_rdata A5C3", 32'(if_rdata), 32'h0000A5C3);
`ifdef CPU_ARB_PERF_EN
    ps = perf_stall_cnt;
    pc = perf_conflict_cnt;
`endif
    run("t2 load+fetch", 1, 0, 1, 16'h0040, 16'h0, 16'h0010, 0, 0, 0, 0);
`ifdef CPU_ARB_PERF_EN
    chk("t6 perf stall", perf_stall_cnt - ps, 32'd5);
    chk("t6 perf conflict", perf_conflict_cnt - pc, 32'd2);
`endif
    run("t3 store", 0, 1, 0, 16'h0100, 16'h1234, 16'h0, 3, 0, 0, 0);
    run("no request", 0, 0, 0, 16'h0, 16'h0, 16'h0, 0, 0, 0, 0);
    run("rd+wr", 1, 1, 1, 16'h0200, 16'h5A5A, 16'h0020, 1, 0, 0, 2);
    for (int i = 0; i < 40; i++)
      run("random", 1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom),
          16'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
          $urandom_range(0, 3));
    do_reset("reset2");
    run("wait 15 ok", 1, 0, 0, 16'h0300, 16'h0, 16'h0, 0, 14, 0, 0);
    run("wait 16 late", 1, 0, 0, 16'h0304, 16'h0, 16'h0, 0, 15, 0, 0);
    run("err sticky", 0, 0, 1, 16'h0, 16'h0, 16'h0308, 0, 0, 0, 0);
    do_reset("reset3");
    run("t4 withheld 20", 0, 0, 1, 16'h0, 16'h0, 16'h0400, 0, 20, 0, 0);
    run("t5 preload", 1, 0, 0, 16'h0500, 16'h0, 16'h0, 0, 0, 0, 0);
    d_rd = 1;
    d_addr = 16'h0504;
    @(negedge clk);
    #1;
    chk("t5 m_req", 32'(m_req), 32'd1);
    m_gnt = 1;
    @(negedge clk);
    m_gnt = 0;
    reset = 0;
    d_rd = 0;
    exp_d = 0; exp_f = 0; exp_err = 0;
    #1;
    chk("t5 rst m_req", 32'(m_req), 32'd0);
    chk("t5 rst d_rdata", 32'(d_rdata), 32'd0);
    chk("t5 rst stall", 32'(stall), 32'd0);
    @(negedge clk);
    reset = 1;
    m_rvalid = 1;
    m_rdata = 16'hBEEF;
    @(negedge clk);
    m_rvalid = 0;
    #1;
    chk("t5 stray d_rdata", 32'(d_rdata), 32'd0);
    chk("t5 stray if_rdata", 32'(if_rdata), 32'd0);
    chk("t5 stray m_req", 32'(m_req), 32'd0);
    chk("t5 stray stall", 32'(stall), 32'd0);
    @(negedge clk);
    run("after reset", 1, 0, 1, 16'h0600, 16'h0, 16'h0610, 1, 1, 1, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
